maze_collision: RTL and testbench

- Per-frame wall-collision detector for the player sprite.
- Once per frame it reads the sprite position, size and direction flags from the sprite mover and probes the maze tile ROM at the two leading-edge corners.
- On a wall hit it drives the opposite-direction bounce request (bnceL/R/U/D) back to the mover for a fixed number of frames.
- Sits between the sprite mover and the maze tile ROM.

---
 rtl/maze_collision.sv | 177 +++++++++++++++++
 tb/tb_maze_collision.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_collision.sv
// maze_collision: once per frame, probes the two leading-edge corners of the
// player sprite against the maze tile ROM. On a wall hit it holds the
// opposite-direction bounce request for BOUNCE_FRAMES frame edges.
module maze_collision #(
    parameter int MAP_W         = 40,
    parameter int MAP_H         = 30,
    parameter int TILE_LOG2     = 4,
    parameter int SCR_W         = 640,
    parameter int SCR_H         = 480,
    parameter int ADDR_W        = 11,
    parameter int BOUNCE_FRAMES = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              spr_on,
    input  logic [9:0]        sprite_xpos,
    input  logic [9:0]        sprite_ypos,
    input  logic [9:0]        sprite_W,
    input  logic [9:0]        sprite_H,
    input  logic              L,
    input  logic              R,
    input  logic              U,
    input  logic              D,
    output logic [ADDR_W-1:0] tile_addr,
    output logic              tile_rd,
    input  logic              tile_data,
    output logic              bnceL,
    output logic              bnceR,
    output logic              bnceU,
    output logic              bnceD,
    output logic              busy,
    output logic [7:0]        hit_count
);

    localparam int HW = $clog2(BOUNCE_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, ADDR0, WAIT0, ADDR1, WAIT1, DECIDE, HOLD} state_t;
    typedef enum logic [1:0] {DIR_L, DIR_R, DIR_U, DIR_D} dir_t;

    state_t            state, state_nxt;
    dir_t              dir_q;
    logic              frame_clk_d, fe;
    logic [9:0]        x_q, y_q, w_q, h_q;
    logic              hit0, hit1;
    logic [ADDR_W-1:0] addr_q;
    logic [HW-1:0]     hold;
    logic [3:0]        bnce;          // {L, R, U, D}
    logic              any_dir, start;

    logic signed [10:0] xs, ys, ws, hs;
    logic signed [10:0] px0, py0, px1, py1;
    logic               oob0, oob1;
    logic [ADDR_W-1:0]  addr0, addr1;

    assign any_dir = L | R | U | D;
    assign start   = (state == IDLE) && fe && spr_on && any_dir;

    assign {bnceL, bnceR, bnceU, bnceD} = bnce;

    // Off-screen (or off-map) probe points count as walls without a ROM read.
    function automatic logic off_map(logic signed [10:0] x, logic signed [10:0] y);
        return x[10] || y[10] ||
               (x[9:0] >= 10'(SCR_W)) || (y[9:0] >= 10'(SCR_H)) ||
               (int'(x[9:TILE_LOG2]) >= MAP_W) || (int'(y[9:TILE_LOG2]) >= MAP_H);
    endfunction

    function automatic logic [ADDR_W-1:0] tile_of(logic signed [10:0] x, logic signed [10:0] y);
        return ADDR_W'(int'(y[9:TILE_LOG2]) * MAP_W + int'(x[9:TILE_LOG2]));
    endfunction

    // Leading-edge probe points from the values latched at frame start.
    always_comb begin
        xs  = $signed({1'b0, x_q});
        ys  = $signed({1'b0, y_q});
        ws  = $signed({1'b0, w_q});
        hs  = $signed({1'b0, h_q});
        px0 = xs;
        py0 = ys;
        px1 = xs;
        py1 = ys;
        case (dir_q)
            DIR_R: begin px0 = xs + ws + 11'sd1; py0 = ys; px1 = px0; py1 = ys + hs; end
            DIR_L: begin px0 = xs - 11'sd1;      py0 = ys; px1 = px0; py1 = ys + hs; end
            DIR_D: begin py0 = ys + hs + 11'sd1; px0 = xs; py1 = py0; px1 = xs + ws; end
            DIR_U: begin py0 = ys - 11'sd1;      px0 = xs; py1 = py0; px1 = xs + ws; end
            default: ;
        endcase
        oob0  = off_map(px0, py0);
        oob1  = off_map(px1, py1);
        addr0 = tile_of(px0, py0);
        addr1 = tile_of(px1, py1);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a dropped sprite aborts from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADDR0;
            ADDR0:   state_nxt = WAIT0;
            WAIT0:   state_nxt = ADDR1;
            ADDR1:   state_nxt = WAIT1;
            WAIT1:   state_nxt = DECIDE;
            DECIDE:  state_nxt = (hit0 | hit1) ? HOLD : IDLE;
            HOLD:    if (fe && hold == HW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!spr_on) state_nxt = IDLE;
    end

    // ROM interface and status outputs; the address holds between probes.
    always_comb begin
        tile_addr = addr_q;
        tile_rd   = 1'b0;
        case (state)
            ADDR0: begin tile_addr = addr0; tile_rd = !oob0; end
            ADDR1: begin tile_addr = addr1; tile_rd = !oob1; end
            default: ;
        endcase
        busy = (state != IDLE);
    end

    // Frame edge detect, sprite latch, probe results, bounce hold and hit counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= 1'b0;
            fe          <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            dir_q       <= DIR_L;
            hit0        <= 1'b0;
            hit1        <= 1'b0;
            addr_q      <= '0;
            hold        <= '0;
            bnce        <= '0;
            hit_count   <= '0;
        end else begin
            frame_clk_d <= frame_clk;
            fe          <= frame_clk & ~frame_clk_d;
            addr_q      <= tile_addr;
            if (start) begin
                x_q   <= sprite_xpos;
                y_q   <= sprite_ypos;
                w_q   <= sprite_W;
                h_q   <= sprite_H;
                dir_q <= L ? DIR_L : R ? DIR_R : U ? DIR_U : DIR_D;
            end
            if (state == WAIT0) hit0 <= oob0 | tile_data;
            if (state == WAIT1) hit1 <= oob1 | tile_data;
            if (!spr_on) begin
                bnce <= '0;
                hold <= '0;
            end else if (state == DECIDE && (hit0 | hit1)) begin
                case (dir_q)
                    DIR_R:   bnce <= 4'b1000;
                    DIR_L:   bnce <= 4'b0100;
                    DIR_D:   bnce <= 4'b0010;
                    default: bnce <= 4'b0001;
                endcase
                hold <= HW'(BOUNCE_FRAMES);
                if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            end else if (state == HOLD && fe) begin
                hold <= hold - HW'(1);
                if (hold == HW'(1)) bnce <= '0;
            end
        end
    end

endmodule

// File: tb/tb_maze_collision.sv
// Randomized + directed bench for maze_collision against a frame-level model.
module tb_maze_collision;

    localparam int BF = 4;

    logic        Clk = 1'b0, Reset, frame_clk, spr_on;
    logic [9:0]  xpos, ypos, sw, sh;
    logic        L, R, U, D;
    logic [10:0] tile_addr;
    logic        tile_rd, tile_data;
    logic        bnceL, bnceR, bnceU, bnceD, busy;
    logic [7:0]  hit_count;

    bit          map [0:2047];
    int          checks = 0, fails = 0, m_hits = 0, rd_cnt = 0;
    wire  [3:0]  bv = {bnceL, bnceR, bnceU, bnceD};

    maze_collision dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spr_on(spr_on),
        .sprite_xpos(xpos), .sprite_ypos(ypos), .sprite_W(sw), .sprite_H(sh),
        .L(L), .R(R), .U(U), .D(D),
        .tile_addr(tile_addr), .tile_rd(tile_rd), .tile_data(tile_data),
        .bnceL(bnceL), .bnceR(bnceR), .bnceU(bnceU), .bnceD(bnceD),
        .busy(busy), .hit_count(hit_count)
    );

    always #5 Clk = ~Clk;

    // Synchronous tile ROM: data valid the cycle after the address.
    always @(posedge Clk) tile_data <= map[tile_addr];

    always @(negedge Clk) if (tile_rd) rd_cnt <= rd_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int s11(input int v);
        int r;
        r = v & 2047;
        return (r >= 1024) ? r - 2048 : r;
    endfunction

    function automatic bit offscr(input int x, input int y);
        return x < 0 || x >= 640 || y < 0 || y >= 480;
    endfunction

    // Frame-level reference: which corners get probed and what bounce results.
    task automatic predict(input int xp, yp, w, h, input bit l, r, u, d,
                           output bit act, output bit o0, o1, output int a0, a1,
                           output logic [3:0] bexp);
        int x0, y0, x1, y1;
        logic [3:0] opp;
        bit hit;
        act = l | r | u | d;
        x0 = xp; y0 = yp; x1 = xp; y1 = yp; opp = 4'b0;
        if (l)      begin x0 = xp - 1;     x1 = x0; y1 = yp + h; opp = 4'b0100; end
        else if (r) begin x0 = xp + w + 1; x1 = x0; y1 = yp + h; opp = 4'b1000; end
        else if (u) begin y0 = yp - 1;     y1 = y0; x1 = xp + w; opp = 4'b0001; end
        else if (d) begin y0 = yp + h + 1; y1 = y0; x1 = xp + w; opp = 4'b0010; end
        x0 = s11(x0); y0 = s11(y0); x1 = s11(x1); y1 = s11(y1);
        o0 = offscr(x0, y0);
        o1 = offscr(x1, y1);
        a0 = o0 ? 0 : (y0 / 16) * 40 + x0 / 16;
        a1 = o1 ? 0 : (y1 / 16) * 40 + x1 / 16;
        hit = o0 | o1 | (!o0 && map[a0]) | (!o1 && map[a1]);
        bexp = (act && hit) ? opp : 4'b0;
    endtask

    task automatic pulse_fe();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
    endtask

    // One frame edge with full probe sequence check; returns expected bounce.
    task automatic run_frame(input int xp, yp, w, h, input bit l, r, u, d,
                             input bit fe_decide, output logic [3:0] bexp);
        bit act, o0, o1;
        int a0, a1, rc0;
        xpos = 10'(xp); ypos = 10'(yp); sw = 10'(w); sh = 10'(h);
        L = l; R = r; U = u; D = d;
        predict(xp, yp, w, h, l, r, u, d, act, o0, o1, a0, a1, bexp);
        rc0 = rd_cnt;
        pulse_fe();
        @(negedge Clk);
        if (!act) begin
            chk("nodir_busy", busy, 0);
            chk("nodir_rd", tile_rd, 0);
            return;
        end
        chk("a0_busy", busy, 1);
        chk("a0_rd", tile_rd, !o0);
        if (!o0) chk("a0_addr", tile_addr, a0);
        repeat (2) @(negedge Clk);
        chk("a1_rd", tile_rd, !o1);
        if (!o1) chk("a1_addr", tile_addr, a1);
        @(negedge Clk) if (fe_decide) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        chk("dec_bnce", bv, 0);
        @(negedge Clk);
        if (bexp != 0 && m_hits < 255) m_hits++;
        chk("bnce", bv, bexp);
        chk("hold_busy", busy, bexp != 0);
        chk("hit_count", hit_count, m_hits);
        chk("rd_pulses", rd_cnt - rc0, int'(!o0) + int'(!o1));
        if (bexp == 0) begin
            @(negedge Clk);
            chk("post_busy", busy, 0);
        end
    endtask

    // Bounce must hold for exactly BF frame edges, then drop with no new probe.
    task automatic release_hold(input logic [3:0] bexp);
        for (int k = 1; k <= BF; k++) begin
            pulse_fe();
            @(negedge Clk);
            chk("onehot", $countones(bv) <= 1, 1);
            if (k < BF) chk("hold_bnce", bv, bexp);
            else begin
                chk("rel_bnce", bv, 0);
                chk("rel_busy", busy, 0);
                @(negedge Clk);
                chk("rel_nostart", busy, 0);
            end
        end
    endtask

    task automatic frame_and_release(input int xp, yp, w, h, input bit l, r, u, d,
                                     input bit fe_decide);
        logic [3:0] b;
        run_frame(xp, yp, w, h, l, r, u, d, fe_decide, b);
        if (b != 0) release_hold(b);
    endtask

    initial begin
        logic [3:0] b;
        Reset = 1'b1; frame_clk = 0; spr_on = 1; xpos = 0; ypos = 0; sw = 0; sh = 0;
        L = 0; R = 0; U = 0; D = 0;
        foreach (map[i]) map[i] = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd", tile_rd, 0);
        chk("rst_addr", tile_addr, 0);
        chk("rst_bnce", bv, 0);
        chk("rst_hits", hit_count, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Wall only at tile 102, moving right.
        map[102] = 1'b1;
        run_frame(336, 33, 20, 20, 0, 1, 0, 0, 0, b);
        chk("t1_bnceL", b, 4'b1000);
        release_hold(b);
        map[102] = 1'b0;

        // Empty map: no bounce.
        frame_and_release(336, 33, 20, 20, 0, 1, 0, 0, 0);
        // No direction: no probe.
        frame_and_release(336, 33, 20, 20, 0, 0, 0, 0, 0);
        // Screen edges are walls.
        frame_and_release(0, 100, 20, 20, 1, 0, 0, 0, 0);
        frame_and_release(100, 460, 20, 20, 0, 0, 0, 1, 0);
        frame_and_release(100, 0, 20, 20, 0, 0, 1, 0, 0);
        frame_and_release(619, 100, 20, 20, 0, 1, 0, 0, 0);
        // L beats U: wall only to the left.
        map[(100 >> 4) * 40 + (99 >> 4)] = 1'b1;
        frame_and_release(100, 100, 20, 20, 1, 0, 1, 0, 0);
        map[(100 >> 4) * 40 + (99 >> 4)] = 1'b0;

        // Frame edge during DECIDE is ignored, with and without a hit.
        frame_and_release(336, 33, 20, 20, 0, 1, 0, 0, 1);
        frame_and_release(0, 100, 20, 20, 1, 0, 0, 0, 1);

        // Drop spr_on during a hold.
        run_frame(0, 100, 20, 20, 1, 0, 0, 0, 0, b);
        @(negedge Clk) spr_on = 1'b0;
        @(negedge Clk) spr_on = 1'b1;
        chk("spr_bnce", bv, 0);
        chk("spr_busy", busy, 0);
        chk("spr_hits", hit_count, m_hits);
        pulse_fe();
        @(negedge Clk);
        chk("spr_idle", busy, 1);   // flags still set, so a fresh probe starts
        repeat (6) @(negedge Clk);
        release_hold(4'b0100);
        if (m_hits < 255) m_hits++;
        chk("spr_hits2", hit_count, m_hits);

        // Reset during WAIT0.
        xpos = 336; ypos = 33; sw = 20; sh = 20; L = 0; R = 1; U = 0; D = 0;
        pulse_fe();
        @(negedge Clk);
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd", tile_rd, 0);
        chk("mid_rst_addr", tile_addr, 0);
        chk("mid_rst_bnce", bv, 0);
        chk("mid_rst_hits", hit_count, 0);
        Reset = 1'b0;
        m_hits = 0;
        @(negedge Clk);

        // Random frames on a random map.
        foreach (map[i]) map[i] = ($urandom_range(0, 3) == 0);
        for (int n = 0; n < 60; n++) begin
            logic [3:0] dirs;
            dirs = 4'($urandom);
            frame_and_release($urandom_range(0, 700), $urandom_range(0, 520),
                              $urandom_range(0, 40), $urandom_range(0, 40),
                              dirs[3], dirs[2], dirs[1], dirs[0], 1'($urandom));
        end

        // Hit counter saturation.
        for (int n = 0; n < 300; n++) frame_and_release(0, 100, 20, 20, 1, 0, 0, 0, 0);
        chk("sat_hits", hit_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
